// File: rtl/maze_pkg.sv
// Shared types and screen constants for the maze runner game sequencer.
package maze_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PLAY       = 3'd1,
    RESPAWN    = 3'd2,
    LEVEL_DONE = 3'd3,
    GAME_OVER  = 3'd4,
    WIN        = 3'd5
  } game_state_t;

  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int PLAYER_SIZE = 25;

  localparam int SW_RIGHT = 0;
  localparam int SW_DOWN  = 1;
  localparam int SW_UP    = 2;
  localparam int SW_LEFT  = 3;

endpackage

// File: rtl/maze_game_ctrl_if.sv
// Link between the game sequencer and the level geometry/renderer blocks.
interface maze_game_ctrl_if;
  logic [1:0] level_sel;
  logic [9:0] player_x;
  logic [9:0] player_y;
  logic       in_path;
  logic       at_finish;

  modport master (output level_sel, player_x, player_y, input in_path, at_finish);
  modport slave  (input level_sel, player_x, player_y, output in_path, at_finish);
endinterface

// File: rtl/maze_tick_gen.sv
// Free-running divider producing a one-cycle move_tick each time it wraps to zero.
module maze_tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic clk,
  input  logic rst_n,
  output logic move_tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      move_tick <= 1'b0;
    end else if (count == CW'(TICK_DIV - 1)) begin
      count     <= '0;
      move_tick <= 1'b1;
    end else begin
      count     <= count + 1'b1;
      move_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/maze_game_ctrl.sv
// Maze runner game sequencer: player position, lives, level select and game state.
module maze_game_ctrl
  import maze_pkg::*;
#(
  parameter int TICK_DIV   = 833333,
  parameter int STEP       = 5,
  parameter int NUM_LEVELS = 3,
  parameter int LIVES      = 3,
  parameter int SPAWN_X    = 13,
  parameter int SPAWN_Y    = 230,
  parameter int X_MAX      = SCREEN_W - PLAYER_SIZE,
  parameter int Y_MAX      = SCREEN_H - PLAYER_SIZE,
  parameter int HOLD_TICKS = 30
) (
  input  logic                    pixel_clk,
  input  logic                    resetSwitch,
  input  logic [3:0]              switches,
  input  logic                    start_btn,
  maze_game_ctrl_if.master        geo,
  output logic [1:0]              lives,
  output game_state_t             game_state,
  output logic                    move_tick
);

  localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [9:0] STEP_V  = 10'(STEP);
  localparam logic [9:0] SPAWN_XV = 10'(SPAWN_X);
  localparam logic [9:0] SPAWN_YV = 10'(SPAWN_Y);
  localparam logic [9:0] X_MAX_V = 10'(X_MAX);
  localparam logic [9:0] Y_MAX_V = 10'(Y_MAX);

  logic [3:0]    sw_meta, sw_sync;
  logic [2:0]    start_sync;
  logic          start;
  logic [9:0]    pos_x, pos_y, next_x, next_y;
  logic [1:0]    level;
  logic [HW-1:0] hold;
  logic          check;
  logic          moved;
  game_state_t   state;

  maze_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk       (pixel_clk),
    .rst_n     (resetSwitch),
    .move_tick (move_tick)
  );

  always_ff @(posedge pixel_clk or negedge resetSwitch) begin
    if (!resetSwitch) begin
      sw_meta    <= '0;
      sw_sync    <= '0;
      start_sync <= '0;
    end else begin
      sw_meta    <= switches;
      sw_sync    <= sw_meta;
      start_sync <= {start_sync[1:0], start_btn};
    end
  end

  assign start = start_sync[1] & ~start_sync[2];

  // One saturating step, left > up > down > right.
  always_comb begin
    next_x = pos_x;
    next_y = pos_y;
    moved  = 1'b1;
    if (sw_sync[SW_LEFT])
      next_x = (pos_x < STEP_V) ? 10'd0 : pos_x - STEP_V;
    else if (sw_sync[SW_UP])
      next_y = (pos_y < STEP_V) ? 10'd0 : pos_y - STEP_V;
    else if (sw_sync[SW_DOWN])
      next_y = (pos_y > Y_MAX_V - STEP_V) ? Y_MAX_V : pos_y + STEP_V;
    else if (sw_sync[SW_RIGHT])
      next_x = (pos_x > X_MAX_V - STEP_V) ? X_MAX_V : pos_x + STEP_V;
    else
      moved = 1'b0;
  end

  always_ff @(posedge pixel_clk or negedge resetSwitch) begin
    if (!resetSwitch) begin
      state <= IDLE;
      level <= 2'd0;
      pos_x <= SPAWN_XV;
      pos_y <= SPAWN_YV;
      lives <= 2'(LIVES);
      hold  <= '0;
      check <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          lives <= 2'(LIVES);
          level <= 2'd0;
          pos_x <= SPAWN_XV;
          pos_y <= SPAWN_YV;
          check <= 1'b0;
          state <= PLAY;
        end
        // The check cycle sees geometry for the position written on the tick before.
        PLAY: if (check) begin
          check <= 1'b0;
          if (geo.at_finish) begin
            hold  <= '0;
            state <= LEVEL_DONE;
          end else if (!geo.in_path) begin
            if (lives == 2'd1) begin
              lives <= 2'd0;
              state <= GAME_OVER;
            end else begin
              lives <= lives - 2'd1;
              pos_x <= SPAWN_XV;
              pos_y <= SPAWN_YV;
              hold  <= '0;
              state <= RESPAWN;
            end
          end
        end else if (move_tick && moved) begin
          pos_x <= next_x;
          pos_y <= next_y;
          check <= 1'b1;
        end
        RESPAWN: if (move_tick) begin
          if (hold == HW'(HOLD_TICKS - 1)) state <= PLAY;
          else                             hold  <= hold + 1'b1;
        end
        LEVEL_DONE: if (move_tick) begin
          if (hold != HW'(HOLD_TICKS - 1)) begin
            hold <= hold + 1'b1;
          end else if (level == 2'(NUM_LEVELS - 1)) begin
            state <= WIN;
          end else begin
            level <= level + 2'd1;
            pos_x <= SPAWN_XV;
            pos_y <= SPAWN_YV;
            state <= PLAY;
          end
        end
        GAME_OVER, WIN: if (start) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign geo.level_sel = level;
  assign geo.player_x  = pos_x;
  assign geo.player_y  = pos_y;
  assign game_state    = state;

endmodule
